// File: rtl/bram_sample_reader.sv
// Burst reader for the sample-capture BRAM: on start, reads length samples from a
// circular buffer (step 1, or a latched stride when ADDR_STRIDE_EN is defined) and
// streams them on valid/ready with tlast; first beat RD_LAT+1 cycles after start.
// Reads are credit-gated against FIFO space so downstream stalls never drop data.
module bram_sample_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 12,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
`ifdef ADDR_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  localparam int CNT_W = $clog2(FIFO_D + 1);
  localparam int PTR_W = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t              state_q;
  logic [ADDR_W:0]     len_q, issued_q, issued_d, len_cur, issued_base;
  logic [ADDR_W-1:0]   addr_q, step_q, start_step, step_cur;
  logic                busy_q, done_q;
  logic [RD_LAT-1:0]   en_sr_q, last_sr_q;
  logic [DATA_W-1:0]   mem_q [FIFO_D];
  logic [FIFO_D-1:0]   last_mem_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         in_flight;
  logic                start_ok, credit_ok, issue, last_issue, push, pop;

`ifdef ADDR_STRIDE_EN
  assign start_step = (stride == '0) ? ADDR_W'(1) : stride;
`else
  assign start_step = ADDR_W'(1);
`endif

  // Reads issued but not yet written into the FIFO still hold a FIFO slot.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LAT; i++) in_flight = in_flight + 32'(en_sr_q[i]);
  end

  assign start_ok    = (state_q == S_IDLE) && start;
  assign credit_ok   = (32'(cnt_q) + in_flight) < 32'(FIFO_D);
  assign len_cur     = start_ok ? length : len_q;
  assign issued_base = start_ok ? '0 : issued_q;
  assign step_cur    = start_ok ? start_step : step_q;
  assign issue       = credit_ok &&
                       ((start_ok && (length != '0)) ||
                        ((state_q == S_READ) && (issued_q < len_q)));
  assign issued_d    = issued_base + {{ADDR_W{1'b0}}, issue};
  assign last_issue  = issue && (issued_d == len_cur);

  // The first read goes out in the start cycle itself, so the address muxes start_addr.
  assign bram_en   = issue;
  assign bram_addr = start_ok ? start_addr : addr_q;

  assign push     = en_sr_q[RD_LAT-1];
  assign m_tvalid = (cnt_q != '0);
  assign m_tdata  = mem_q[rd_ptr_q];
  assign m_tlast  = m_tvalid && last_mem_q[rd_ptr_q];
  assign pop      = m_tvalid && m_tready;
  assign busy     = busy_q;
  assign done     = done_q;

  // Burst control FSM: latch request, count issued reads, finish on last handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      issued_q <= '0;
      addr_q   <= '0;
      step_q   <= ADDR_W'(1);
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (length == '0) begin
              done_q <= 1'b1;
            end else begin
              len_q    <= length;
              step_q   <= start_step;
              issued_q <= issued_d;
              addr_q   <= issue ? (bram_addr + step_cur) : start_addr;
              busy_q   <= 1'b1;
              state_q  <= (issued_d == length) ? S_DRAIN : S_READ;
            end
          end
        end
        S_READ: begin
          if (issue) begin
            issued_q <= issued_d;
            addr_q   <= bram_addr + step_cur;
            if (issued_d == len_q) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pop && m_tlast) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Delay line matching BRAM latency: marks which cycle bram_dout carries a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_sr_q   <= '0;
      last_sr_q <= '0;
    end else begin
      en_sr_q[0]   <= issue;
      last_sr_q[0] <= last_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        en_sr_q[i]   <= en_sr_q[i-1];
        last_sr_q[i] <= last_sr_q[i-1];
      end
    end
  end

  // Output FIFO; writes are never refused because reads were credit-gated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_D; i++) mem_q[i] <= '0;
      last_mem_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q]      <= bram_dout;
        last_mem_q[wr_ptr_q] <= last_sr_q[RD_LAT-1];
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_bram_sample_reader.sv
// Bench for bram_sample_reader: BRAM model preloaded with mem[i]=i, scoreboard of
// expected beats pushed at start and popped on every handshake.
module tb_bram_sample_reader;
  localparam int AW = 5;
  localparam int DW = 12;
  localparam int RL = 1;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, busy, done, bram_en, m_tvalid, m_tready, m_tlast;
  logic [AW-1:0] start_addr, bram_addr;
  logic [AW:0]   length;
  logic [DW-1:0] bram_dout, m_tdata;
`ifdef ADDR_STRIDE_EN
  logic [AW-1:0] stride;
`endif

  always #5 clk = ~clk;

  bram_sample_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .FIFO_D(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
`ifdef ADDR_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .bram_en(bram_en), .bram_addr(bram_addr),
    .bram_dout(bram_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast));

  // BRAM model
  logic [DW-1:0] bmem [32];
  logic [DW-1:0] d1, d2;
  initial for (int i = 0; i < 32; i++) bmem[i] = DW'(i);
  always @(posedge clk) begin
    if (bram_en) d1 <= bmem[bram_addr];
    d2 <= d1;
  end
  assign bram_dout = (RL == 1) ? d1 : d2;

  typedef struct packed { logic [DW-1:0] d; logic l; } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, beats = 0, first_cyc = 0, last_cyc = 0;
  bit tvalid_seen = 0, stall_q = 0, tog_mode = 0;
  logic [DW-1:0] stall_dat;
  int pidx = 0;
  bit pat [5] = '{1, 0, 0, 1, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // m_tready toggle pattern 1,0,0,1,0 repeating
  always @(posedge clk) begin
    #1;
    if (tog_mode) begin
      m_tready = pat[pidx];
      pidx = (pidx + 1) % 5;
    end
  end

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (done) done_cnt++;
    if (m_tvalid) tvalid_seen = 1;
    if (stall_q) begin
      check("stall_vld", 32'(m_tvalid), 1);
      check("stall_dat", 32'(m_tdata), 32'(stall_dat));
    end
    if (m_tvalid && m_tready) begin
      if (beats == 0) first_cyc = cyc;
      last_cyc = cyc;
      beats++;
      check("beat_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("tdata", 32'(m_tdata), 32'(e.d));
        check("tlast", 32'(m_tlast), 32'(e.l));
      end
    end
    stall_q   = m_tvalid && !m_tready && rst_n;
    stall_dat = m_tdata;
  end

  task automatic push_seq(input int a, input int l, input int st);
    exp_t e;
    for (int i = 0; i < l; i++) begin
      e.d = DW'((a + i * st) % 32);
      e.l = (i == l - 1);
      sb.push_back(e);
    end
  endtask

  // Drive start for one cycle from the current time; returns at cycle 1 (+1 after edge).
  task automatic pulse_start(input int a, input int l, input int s);
    start_addr = AW'(a);
    length     = (AW+1)'(l);
`ifdef ADDR_STRIDE_EN
    stride     = AW'(s);
`endif
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (done) seen = 1;
    end
    check(tag, 32'(seen), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; m_tready = 1'b1;
`ifdef ADDR_STRIDE_EN
    stride = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_en", 32'(bram_en), 0);
    check("rst_addr", 32'(bram_addr), 0);
    check("rst_vld", 32'(m_tvalid), 0);
    check("rst_last", 32'(m_tlast), 0);
    check("rst_dat", 32'(m_tdata), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Burst 0..9 at full rate, first-beat latency
    push_seq(0, 10, 1);
    beats = 0; d0 = done_cnt;
    pulse_start(0, 10, 1);
    check("t1_busy", 32'(busy), 1);
    check("t1_vld_early", 32'(m_tvalid), 0);
    @(posedge clk); #1;
    check("t1_first_vld", 32'(m_tvalid), 1);
    check("t1_first_dat", 32'(m_tdata), 0);
    wait_done(60, "t1_done");
    check("t1_beats", 32'(beats), 10);
    check("t1_rate", 32'(last_cyc - first_cyc), 9);
    check("t1_busy_at_done", 32'(busy), 0);

    // Start in the done cycle: accepted, wraps 28..3
    push_seq(28, 8, 1);
    beats = 0;
    pulse_start(28, 8, 1);
    check("t2_accept", 32'(busy), 1);
    wait_done(60, "t2_done");
    check("t2_beats", 32'(beats), 8);
    check("t2_sb_empty", 32'(sb.size()), 0);
    check("t12_done_cnt", 32'(done_cnt - d0), 2);
    @(posedge clk); #1;

    // Backpressure with toggling ready
    push_seq(0, 5, 1);
    beats = 0; pidx = 0; tog_mode = 1;
    pulse_start(0, 5, 1);
    wait_done(100, "t3_done");
    tog_mode = 0;
    @(posedge clk); #1;
    m_tready = 1'b1;
    check("t3_beats", 32'(beats), 5);
    check("t3_sb_empty", 32'(sb.size()), 0);

    // Zero length
    repeat (2) @(posedge clk);
    #1;
    tvalid_seen = 0; d0 = done_cnt;
    pulse_start(7, 0, 1);
    check("t4_done", 32'(done), 1);
    check("t4_busy", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("t4_no_vld", 32'(tvalid_seen), 0);
    check("t4_done_once", 32'(done_cnt - d0), 1);

    // Start while busy is ignored
    push_seq(0, 10, 1);
    beats = 0; d0 = done_cnt;
    pulse_start(0, 10, 1);
    @(posedge clk); #1;
    pulse_start(20, 5, 1);
    wait_done(60, "t5_done");
    repeat (10) @(posedge clk);
    #1;
    check("t5_beats", 32'(beats), 10);
    check("t5_done_once", 32'(done_cnt - d0), 1);
    check("t5_sb_empty", 32'(sb.size()), 0);

    // Reset mid-burst, then a clean burst
    push_seq(3, 10, 1);
    beats = 0;
    pulse_start(3, 10, 1);
    for (int i = 0; i < 40 && beats < 4; i++) begin
      @(posedge clk); #1;
    end
    check("t6_reach4", 32'(beats), 4);
    rst_n = 1'b0;
    #1;
    check("t6_vld", 32'(m_tvalid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_en", 32'(bram_en), 0);
    check("t6_last", 32'(m_tlast), 0);
    sb.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_no_done", 32'(done_cnt - d0), 0);
    check("t6_idle_vld", 32'(m_tvalid), 0);
    push_seq(5, 6, 1);
    beats = 0;
    pulse_start(5, 6, 1);
    wait_done(60, "t6_done");
    check("t6_beats", 32'(beats), 6);
    check("t6_sb_empty", 32'(sb.size()), 0);

`ifdef ADDR_STRIDE_EN
    // Stride 4, then stride 0 (treated as 1)
    @(posedge clk); #1;
    push_seq(2, 8, 4);
    beats = 0;
    pulse_start(2, 8, 4);
    wait_done(60, "t7_done");
    check("t7_beats", 32'(beats), 8);
    @(posedge clk); #1;
    push_seq(2, 8, 1);
    beats = 0;
    pulse_start(2, 8, 0);
    wait_done(60, "t8_done");
    check("t8_beats", 32'(beats), 8);
    check("t8_sb_empty", 32'(sb.size()), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
